// File: rtl/regfile_writeback_arbiter_pkg.sv
// wb_pkg: shared widths, FIFO entry type and index decode
// for the register file write-back path.
package wb_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [REG_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(
    input logic [REG_W-1:0] r
  );
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Producer offers (ALU, load path) and the register
// file write port of the write-back arbiter.
interface regfile_writeback_arbiter_if;
  import wb_pkg::*;

  logic              Alu_Valid;
  logic [REG_W-1:0]  Alu_Reg;
  logic [DATA_W-1:0] Alu_Data;
  logic              Alu_Ready;

  logic              Mem_Valid;
  logic [REG_W-1:0]  Mem_Reg;
  logic [DATA_W-1:0] Mem_Data;
  logic              Mem_Ready;

  logic [REG_W-1:0]  Write_Reg;
  logic [DATA_W-1:0] Write_Data;
  logic              RegWrite;

  modport slave (
    input  Alu_Valid, Alu_Reg, Alu_Data,
    input  Mem_Valid, Mem_Reg, Mem_Data,
    output Alu_Ready, Mem_Ready,
    output Write_Reg, Write_Data, RegWrite
  );

  modport master (
    output Alu_Valid, Alu_Reg, Alu_Data,
    output Mem_Valid, Mem_Reg, Mem_Data,
    input  Alu_Ready, Mem_Ready,
    input  Write_Reg, Write_Data, RegWrite
  );

endinterface

// File: rtl/regfile_writeback_arbiter_fifo.sv
// wb_fifo: circular FIFO of write-back entries with
// per-slot and oldest-first views for scanning.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       push_i,
  input  wb_entry_t                  wr_entry_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DEPTH-1:0]           slot_valid_o,
  output wb_entry_t                  slot_entry_o [DEPTH],
  output logic [DEPTH-1:0]           age_valid_o,
  output wb_entry_t                  age_entry_o [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q < CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign count_o = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wr_entry_i;
    end
  end

  // Slot view and oldest-first view of the storage.
  always_comb begin
    logic [PW-1:0] off;
    for (int i = 0; i < DEPTH; i++) begin
      off             = PW'(i) - rd_ptr_q;
      slot_valid_o[i] = CW'(off) < count_q;
      slot_entry_o[i] = mem_q[i];
      age_valid_o[i]  = CW'(i) < count_q;
      age_entry_o[i]  = mem_q[rd_ptr_q + PW'(i)];
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Write-back arbiter: ALU/load accept, r0 filter, FIFO,
// flopped RF write port, pending mask. Option: WB_FORWARD_EN.
module regfile_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  regfile_writeback_arbiter_if.slave bus,
  input  logic                       Wb_Hold,
  output logic [NUM_REGS-1:0]        Pending_Mask,
  output logic                       Empty
`ifdef WB_FORWARD_EN
  ,
  input  logic [REG_W-1:0]           Fwd_Reg,
  output logic                       Fwd_Hit,
  output logic [DATA_W-1:0]          Fwd_Data
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  slot_valid;
  wb_entry_t         slot_entry [DEPTH];
  logic [DEPTH-1:0]  age_valid;
  wb_entry_t         age_entry [DEPTH];

  logic              not_full;
  logic              mem_acc, alu_acc;
  wb_entry_t         in_entry;
  logic              push, pop;

  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;

  // Readies look only at pre-pop occupancy.
  assign not_full      = count < CW'(DEPTH);
  assign bus.Mem_Ready = not_full;
  assign bus.Alu_Ready = not_full && !bus.Mem_Valid;

  assign mem_acc = bus.Mem_Valid && not_full;
  assign alu_acc = bus.Alu_Valid && not_full
                   && !bus.Mem_Valid;

  // Select the accepted offer; r0 writes are dropped.
  always_comb begin
    in_entry = '0;
    push     = 1'b0;
    if (mem_acc) begin
      in_entry.idx  = bus.Mem_Reg;
      in_entry.data = bus.Mem_Data;
    end else begin
      in_entry.idx  = bus.Alu_Reg;
      in_entry.data = bus.Alu_Data;
    end
    push = (mem_acc || alu_acc) && (in_entry.idx != '0);
  end

  assign pop = !Wb_Hold && age_valid[0];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk          (Clk),
    .Rst          (Rst),
    .push_i       (push),
    .wr_entry_i   (in_entry),
    .pop_i        (pop),
    .count_o      (count),
    .slot_valid_o (slot_valid),
    .slot_entry_o (slot_entry),
    .age_valid_o  (age_valid),
    .age_entry_o  (age_entry)
  );

  // Output stage next-state: load head on pop, else hold.
  always_comb begin
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    rw_d    = pop;
    if (pop) begin
      wreg_d  = age_entry[0].idx;
      wdata_d = age_entry[0].data;
    end
  end

  // Output stage registers feeding the RF write port.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wreg_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
    end
  end

  assign bus.Write_Reg  = wreg_q;
  assign bus.Write_Data = wdata_q;
  assign bus.RegWrite   = rw_q;
  assign Empty          = (count == '0) && !rw_q;

  // Registers with a write queued or on the port.
  always_comb begin
    Pending_Mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_valid[i])
        Pending_Mask |= reg_onehot(slot_entry[i].idx);
    if (rw_q)
      Pending_Mask |= reg_onehot(wreg_q);
    Pending_Mask[0] = 1'b0;
  end

`ifdef WB_FORWARD_EN
  // Youngest match wins; output stage is the oldest.
  always_comb begin
    Fwd_Hit  = 1'b0;
    Fwd_Data = '0;
    if (rw_q && (wreg_q == Fwd_Reg)) begin
      Fwd_Hit  = 1'b1;
      Fwd_Data = wdata_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (age_entry[k].idx == Fwd_Reg)) begin
        Fwd_Hit  = 1'b1;
        Fwd_Data = age_entry[k].data;
      end
    end
    if (Fwd_Reg == '0) begin
      Fwd_Hit  = 1'b0;
      Fwd_Data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter.
// Expected values are hand-derived per step.
module tb_regfile_writeback_arbiter;
  import wb_pkg::*;

  logic Clk;
  logic Rst;
  logic Wb_Hold;
  logic [NUM_REGS-1:0] Pending_Mask;
  logic Empty;
`ifdef WB_FORWARD_EN
  logic [REG_W-1:0]  Fwd_Reg;
  logic              Fwd_Hit;
  logic [DATA_W-1:0] Fwd_Data;
`endif

  int n_assert;
  int n_fail;

  regfile_writeback_arbiter_if bus ();

  regfile_writeback_arbiter #(.DEPTH(4)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .bus          (bus),
    .Wb_Hold      (Wb_Hold),
    .Pending_Mask (Pending_Mask),
    .Empty        (Empty)
`ifdef WB_FORWARD_EN
    ,
    .Fwd_Reg      (Fwd_Reg),
    .Fwd_Hit      (Fwd_Hit),
    .Fwd_Data     (Fwd_Data)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic alu(input logic v,
                     input logic [REG_W-1:0] r,
                     input logic [DATA_W-1:0] d);
    bus.Alu_Valid = v;
    bus.Alu_Reg   = r;
    bus.Alu_Data  = d;
  endtask

  task automatic mem(input logic v,
                     input logic [REG_W-1:0] r,
                     input logic [DATA_W-1:0] d);
    bus.Mem_Valid = v;
    bus.Mem_Reg   = r;
    bus.Mem_Data  = d;
  endtask

  task automatic wport(input string tag,
                       input logic rw,
                       input logic [REG_W-1:0] r,
                       input logic [DATA_W-1:0] d);
    chk({tag, "_rw"}, 32'(bus.RegWrite), 32'(rw));
    chk({tag, "_reg"}, 32'(bus.Write_Reg), 32'(r));
    chk({tag, "_data"}, 32'(bus.Write_Data), 32'(d));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    Rst      = 1'b1;
    Wb_Hold  = 1'b0;
    alu(1'b0, '0, '0);
    mem(1'b0, '0, '0);
`ifdef WB_FORWARD_EN
    Fwd_Reg = '0;
`endif
    #1;
    // reset state
    wport("rst", 1'b0, 4'd0, 16'h0000);
    chk("rst_mask", 32'(Pending_Mask), 32'h0);
    chk("rst_empty", 32'(Empty), 32'd1);
    chk("rst_mrdy", 32'(bus.Mem_Ready), 32'd1);
    chk("rst_ardy", 32'(bus.Alu_Ready), 32'd1);
    mem(1'b1, 4'd0, 16'h0);
    #1;
    chk("rst_ardy_mv", 32'(bus.Alu_Ready), 32'd0);
    mem(1'b0, 4'd0, 16'h0);
    tick();
    Rst = 1'b0;
    tick();

    // single write
    alu(1'b1, 4'd3, 16'hBEEF);
    #1;
    chk("s_ardy", 32'(bus.Alu_Ready), 32'd1);
    tick();
    alu(1'b0, 4'd0, 16'h0);
    chk("s_rw0", 32'(bus.RegWrite), 32'd0);
    chk("s_mask0", 32'(Pending_Mask), 32'h0008);
    chk("s_empty0", 32'(Empty), 32'd0);
    tick();
    wport("s_out", 1'b1, 4'd3, 16'hBEEF);
    chk("s_mask1", 32'(Pending_Mask), 32'h0008);
    tick();
    wport("s_done", 1'b0, 4'd3, 16'hBEEF);
    chk("s_mask2", 32'(Pending_Mask), 32'h0);
    chk("s_empty2", 32'(Empty), 32'd1);

    // contention
    mem(1'b1, 4'd5, 16'h1111);
    alu(1'b1, 4'd6, 16'h2222);
    #1;
    chk("c_mrdy", 32'(bus.Mem_Ready), 32'd1);
    chk("c_ardy", 32'(bus.Alu_Ready), 32'd0);
    tick();
    mem(1'b0, 4'd0, 16'h0);
    #1;
    chk("c_ardy2", 32'(bus.Alu_Ready), 32'd1);
    chk("c_mask", 32'(Pending_Mask), 32'h0020);
    tick();
    alu(1'b0, 4'd0, 16'h0);
    wport("c_w5", 1'b1, 4'd5, 16'h1111);
    chk("c_mask2", 32'(Pending_Mask), 32'h0060);
    tick();
    wport("c_w6", 1'b1, 4'd6, 16'h2222);
    tick();
    chk("c_rwoff", 32'(bus.RegWrite), 32'd0);

    // full / hold
    Wb_Hold = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      alu(1'b1, 4'(r), 16'(16'h00A0 + r));
      tick();
    end
    alu(1'b0, 4'd0, 16'h0);
    chk("f_mrdy", 32'(bus.Mem_Ready), 32'd0);
    chk("f_ardy", 32'(bus.Alu_Ready), 32'd0);
    chk("f_mask", 32'(Pending_Mask), 32'h001E);
    chk("f_rw", 32'(bus.RegWrite), 32'd0);
    Wb_Hold = 1'b0;
    #1;
    chk("f_prepop", 32'(bus.Mem_Ready), 32'd0);
    tick();
    wport("f_w1", 1'b1, 4'd1, 16'h00A1);
    chk("f_mrdy2", 32'(bus.Mem_Ready), 32'd1);
    chk("f_ardy2", 32'(bus.Alu_Ready), 32'd1);
    for (int r = 2; r <= 4; r++) begin
      tick();
      wport("f_wn", 1'b1, 4'(r), 16'(16'h00A0 + r));
    end
    tick();
    chk("f_rwoff", 32'(bus.RegWrite), 32'd0);
    chk("f_empty", 32'(Empty), 32'd1);

    // register 0
    alu(1'b1, 4'd0, 16'hFFFF);
    #1;
    chk("z_ardy", 32'(bus.Alu_Ready), 32'd1);
    tick();
    alu(1'b0, 4'd0, 16'h0);
    chk("z_mask", 32'(Pending_Mask), 32'h0);
    chk("z_empty", 32'(Empty), 32'd1);
    tick();
    chk("z_rw", 32'(bus.RegWrite), 32'd0);
    chk("z_empty2", 32'(Empty), 32'd1);

    // reset mid-drain
    Wb_Hold = 1'b1;
    for (int r = 8; r <= 10; r++) begin
      alu(1'b1, 4'(r), 16'(16'h0C00 + r));
      tick();
    end
    alu(1'b0, 4'd0, 16'h0);
    Wb_Hold = 1'b0;
    tick();
    wport("r_w8", 1'b1, 4'd8, 16'h0C08);
    #2;
    Rst = 1'b1;
    #1;
    wport("r_rst", 1'b0, 4'd0, 16'h0000);
    chk("r_mask", 32'(Pending_Mask), 32'h0);
    chk("r_empty", 32'(Empty), 32'd1);
    #1;
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_norw", 32'(bus.RegWrite), 32'd0);
    end
    chk("r_empty2", 32'(Empty), 32'd1);

`ifdef WB_FORWARD_EN
    // forwarding
    Wb_Hold = 1'b1;
    alu(1'b1, 4'd2, 16'h0001);
    tick();
    alu(1'b1, 4'd2, 16'h0002);
    tick();
    alu(1'b0, 4'd0, 16'h0);
    Fwd_Reg = 4'd2;
    #1;
    chk("fw_hit", 32'(Fwd_Hit), 32'd1);
    chk("fw_data", 32'(Fwd_Data), 32'h0002);
    Fwd_Reg = 4'd7;
    #1;
    chk("fw_miss", 32'(Fwd_Hit), 32'd0);
    chk("fw_mdata", 32'(Fwd_Data), 32'h0);
    Wb_Hold = 1'b0;
    tick();
    tick();
    tick();
    chk("fw_empty", 32'(Empty), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
